// File: rtl/word_arb_pkg.sv
// rtl/word_arb_pkg.sv - shared sizes and output-stage state for the word source arbiter
package word_arb_pkg;

    localparam int N_PORTS = 16;
    localparam int WORD_W  = 32;
    localparam int SEL_W   = 4;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - round-robin winner pick: rotate by ptr, find first, rotate back
module rr_priority_pick
    import word_arb_pkg::*;
(
    input  logic [N_PORTS-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   idx,
    output logic               found
);

    logic [SEL_W:0]     lsh;
    logic [N_PORTS-1:0] rot;
    logic [SEL_W-1:0]   off;

    // Bit 0 of rot is req[ptr]; a shift by N_PORTS (ptr==0) clears the wrapped half
    assign lsh = (SEL_W+1)'(N_PORTS) - {1'b0, ptr};
    assign rot = (req >> ptr) | (req << lsh);

    always_comb begin
        off = '0;
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = i[SEL_W-1:0];
            end
        end
    end

    assign idx   = off + ptr;
    assign found = |req;

endmodule

// File: rtl/word_source_rr_arbiter.sv
// rtl/word_source_rr_arbiter.sv - fair 16-source word arbiter with a registered valid/ready output
module word_source_rr_arbiter #(
    parameter int N_PORTS = word_arb_pkg::N_PORTS,
    parameter int WORD_W  = word_arb_pkg::WORD_W,
    parameter int SEL_W   = word_arb_pkg::SEL_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_PORTS-1:0]        req,
    input  logic [N_PORTS*WORD_W-1:0] data_in,
    output logic [N_PORTS-1:0]        gnt,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WORD_W-1:0]         out_data,
    output logic [SEL_W-1:0]          out_sel
);

    word_arb_pkg::arb_state_e state;
    logic [SEL_W-1:0]         ptr;
    logic [SEL_W-1:0]         idx;
    logic                     found;
    logic                     load;

    rr_priority_pick u_pick (
        .req   (req),
        .ptr   (ptr),
        .idx   (idx),
        .found (found)
    );

    assign out_valid = (state == word_arb_pkg::FULL);
    assign load      = found & (~out_valid | out_ready);
    // Masked by rst_n so no source believes it was captured while reset is held
    assign gnt       = (load & rst_n) ? (N_PORTS'(1) << idx) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= word_arb_pkg::EMPTY;
            out_data <= '0;
            out_sel  <= '0;
            ptr      <= '0;
        end else if (load) begin
            state    <= word_arb_pkg::FULL;
            out_data <= data_in[idx*WORD_W +: WORD_W];
            out_sel  <= idx;
            ptr      <= idx + SEL_W'(1);
        end else if (out_valid && out_ready) begin
            state    <= word_arb_pkg::EMPTY;
        end
    end

endmodule

// File: tb/tb_word_source_rr_arbiter.sv
// tb/tb_word_source_rr_arbiter.sv - scoreboard bench for word_source_rr_arbiter
module tb_word_source_rr_arbiter;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [15:0]   req;
    logic [511:0]  data_in;
    logic [15:0]   gnt;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic [3:0]    out_sel;

    int            n_tests = 0;
    int            n_fail  = 0;

    logic [35:0]   sb_q[$];
    logic [35:0]   m_last;
    int            m_ptr;
    logic          m_valid;

    word_source_rr_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data_in   (data_in),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference model: simple scan from m_ptr, advanced between edges on the falling edge
    always @(negedge clk) begin
        int          m_idx;
        int          j;
        logic        m_found;
        logic        m_load;
        logic [15:0] exp_gnt;
        logic [35:0] w;
        if (!rst_n) begin
            check_eq("rst_gnt", gnt, 0);
            check_eq("rst_valid", out_valid, 0);
            check_eq("rst_data", out_data, 0);
            check_eq("rst_sel", out_sel, 0);
            m_ptr   = 0;
            m_valid = 1'b0;
            m_last  = '0;
            sb_q.delete();
        end else begin
            m_found = 1'b0;
            m_idx   = 0;
            for (int k = 0; k < 16; k++) begin
                j = (m_ptr + k) % 16;
                if (!m_found && req[j]) begin
                    m_found = 1'b1;
                    m_idx   = j;
                end
            end
            m_load  = m_found && (!m_valid || out_ready);
            exp_gnt = m_load ? (16'd1 << m_idx) : 16'd0;
            check_eq("mon_gnt", gnt, exp_gnt);
            check_eq("mon_valid", out_valid, m_valid);
            if (m_valid && sb_q.size() > 0)
                check_eq("mon_word", {out_sel, out_data}, sb_q[0]);
            else if (!m_valid)
                check_eq("mon_hold", {out_sel, out_data}, m_last);
            if (m_valid && out_ready && sb_q.size() > 0)
                void'(sb_q.pop_front());
            if (m_load) begin
                w = {4'(m_idx), data_in[m_idx*32 +: 32]};
                sb_q.push_back(w);
                m_last  = w;
                m_ptr   = (m_idx + 1) % 16;
                m_valid = 1'b1;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        req   = '0;
        @(negedge clk);
        tick();
        rst_n = 1'b1;
    endtask

    task automatic set_index_data();
        for (int i = 0; i < 16; i++) data_in[i*32 +: 32] = 32'(i);
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        out_ready = 1'b0;
        data_in   = '0;

        // reset held with random requests
        #1;
        req = 16'($urandom) | 16'h0001;
        repeat (3) begin
            @(negedge clk);
            check_eq("t1_gnt", gnt, 0);
            check_eq("t1_valid", out_valid, 0);
        end
        tick();
        rst_n = 1'b1;

        // single request
        req = 16'h0001;
        data_in[31:0] = 32'hDEAD_BEEF;
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("t2_gnt", gnt, 16'h0001);
        tick();
        req = '0;
        check_eq("t2_valid", out_valid, 1);
        check_eq("t2_data", out_data, 32'hDEAD_BEEF);
        check_eq("t2_sel", out_sel, 0);

        // full-load rotation
        do_reset();
        set_index_data();
        req = 16'hFFFF;
        out_ready = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            tick();
            check_eq("t3_valid", out_valid, 1);
            check_eq("t3_sel", out_sel, k % 16);
            check_eq("t3_data", out_data, k % 16);
        end

        // backpressure
        do_reset();
        out_ready = 1'b1;
        req = 16'h0008;
        tick();
        out_ready = 1'b0;
        req = 16'hFFFF;
        check_eq("t4_sel0", out_sel, 3);
        repeat (5) begin
            @(negedge clk);
            check_eq("t4_stall_gnt", gnt, 0);
            tick();
            check_eq("t4_stall_sel", out_sel, 3);
            check_eq("t4_stall_data", out_data, 3);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("t4_resume_gnt", gnt, 16'h0010);
        tick();
        check_eq("t4_resume_sel", out_sel, 4);

        // wrap-around
        do_reset();
        out_ready = 1'b1;
        req = 16'h4000;
        tick();
        req = 16'h8008;
        tick();
        check_eq("t5_sel15", out_sel, 15);
        tick();
        check_eq("t5_sel3", out_sel, 3);

        // reset during stall
        do_reset();
        out_ready = 1'b1;
        req = 16'h0020;
        tick();
        out_ready = 1'b0;
        req = 16'h0030;
        tick();
        tick();
        check_eq("t6_pre_valid", out_valid, 1);
        check_eq("t6_pre_sel", out_sel, 5);
        rst_n = 1'b0;
        #1;
        check_eq("t6_async_valid", out_valid, 0);
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("t6_first_gnt", gnt, 16'h0010);
        tick();
        check_eq("t6_first_sel", out_sel, 4);

        // random traffic, checked by the model
        for (int c = 0; c < 400; c++) begin
            tick();
            req       = 16'($urandom) & 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 16; i++) data_in[i*32 +: 32] = $urandom;
        end
        tick();
        req = '0;
        out_ready = 1'b1;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/word_source_rr_arbiter.md
# word_source_rr_arbiter

Round-robin arbiter and output stage that shares one 32-bit word path between 16 requesters. Each cycle it picks at most one requesting source, selects its word, registers it, and presents it downstream on a valid/ready handshake. It sits in front of the 16-input 32-bit word-select datapath and drives its select, turning a free-running combinational mux into a fair, flow-controlled source.

## Interface

**Parameters**
- `N_PORTS`, default 16: number of requesters. Fixed at 16 for this revision.
- `WORD_W`, default 32: word width.
- `SEL_W`, default 4: index width, log2(`N_PORTS`).

**Ports**
- `clk` in, 1: single clock, rising edge.
- `rst_n` in, 1: asynchronous, active-low reset.
- `req` in, 16: per-source request. Level-sensitive. The source holds it until it sees its grant.
- `data_in` in, 16*32: packed source words. Source i occupies bits [32*i+31 : 32*i]. The word must be stable while `req[i]` is high.
- `gnt` out, 16: one-hot capture pulse. Asserted combinationally in the cycle source i's word is loaded.
- `out_valid` out, 1: registered output word is valid.
- `out_ready` in, 1: downstream accepts the word.
- `out_data` out, 32: registered selected word.
- `out_sel` out, 4: registered index of the source of `out_data`.

## Operation

- **Pointer.** `ptr` (4 bits) marks the highest-priority index. Reset value is 0.
- **Pick.** The winner is the first i with `req[i]=1`, scanning `ptr`, `ptr+1`, … with wrap 15→0. `found` is the OR of `req`.
- **Load condition.** `load = found & (~out_valid | out_ready)`.
- **On load:**
  - `gnt[idx]=1` in that cycle.
  - `out_data <= data_in[idx]`, `out_sel <= idx`, `out_valid <= 1`, `ptr <= idx+1` mod 16.
- **Handshake with no new load** (`out_valid & out_ready & ~found`): `out_valid <= 0`. `out_data` and `out_sel` hold their last values.
- **Backpressure** (`out_valid & ~out_ready`):
  - No load, `gnt=0`.
  - `out_data`, `out_sel` and `ptr` hold.
  - Requests may arrive or drop freely in this state.
- **Simultaneous handshake and request:** the new word loads in the same cycle the old word is accepted. The pick uses the current `ptr`, which was already advanced past the previous winner, so sustained throughput is 1 word/cycle.
- **Granted source still requesting:** a granted source must drop `req` in the cycle after `gnt`. If it stays high, it is treated as a new request at lowest priority. This is legal and fair.
- **Ignored inputs:**
  - `out_ready` is ignored while `out_valid=0`.
  - `data_in` of non-selected sources is ignored.
- **States:**
  - EMPTY: `out_valid=0`. Goes to FULL on load.
  - FULL: `out_valid=1`. Stays FULL on load or stall. Goes to EMPTY on handshake without load.

## Timing

- **Reset values:** `out_valid=0`, `out_data=0`, `out_sel=0`, `ptr=0`. `gnt=0` while reset is asserted.
- **Reset mid-operation:** `out_valid` drops asynchronously. The held word is discarded, not delivered. Arbitration after release restarts at index 0.
- **Latency:** `req[i]` high in cycle t with the block EMPTY gives `gnt[i]` in cycle t and `out_valid`/`out_data` in cycle t+1.
- **Combinational paths:** `gnt` depends on `req`, `ptr`, `out_valid` and `out_ready`. There is no combinational path from `data_in` to any output.

## Structure

- **Shared package `word_arb_pkg`:**
  - `N_PORTS=16`, `WORD_W=32`, `SEL_W=4`.
  - State enum {EMPTY, FULL}.
- **Sub-module `rr_priority_pick`:** combinational. Inputs `req[15:0]` and `ptr[3:0]`; outputs `idx[3:0]` and `found`. Implement it by rotate-right by `ptr`, then a fixed-priority find-first, then add `ptr` mod 16.
- **Word select:** indexed part-select of `data_in` by `idx`, inside the top module.

## Test plan

1. **Reset:** hold `rst_n=0`, assert random `req`. Expect `out_valid=0`, `out_data=0`, `out_sel=0`, `gnt=0`.
2. **Single request:**
   - Stimulus: `req=16'h0001`, `data_in[0]=32'hDEAD_BEEF`, `out_ready=1`.
   - Expect `gnt=16'h0001` in the same cycle.
   - Next cycle: `out_valid=1`, `out_data=32'hDEAD_BEEF`, `out_sel=0`.
3. **Full-load rotation:**
   - Stimulus: `req=16'hFFFF` held, `out_ready=1`, `data_in[i]=i`.
   - Expect `out_sel` = 0,1,…,15,0 on consecutive cycles, `out_data` equal to `out_sel`, and `out_valid` continuously high.
4. **Backpressure:**
   - Stimulus: FULL with `out_sel=3`, then `out_ready=0` for 5 cycles with `req=16'hFFFF`.
   - During the stall: `gnt=0`, and `out_data`/`out_sel` stay stable.
   - On raising `out_ready`: handshake completes and the next `out_sel=4` loads in the same cycle.
5. **Wrap-around:**
   - Stimulus: last grant was 14 (`ptr=15`), `req=16'h8008`.
   - Expect `out_sel=15` first, then 3.
6. **Reset during stall:**
   - Stimulus: `out_valid=1`, `out_ready=0`, `req=16'h0030`, `ptr=6`. Pulse `rst_n` low.
   - `out_valid` goes to 0 immediately.
   - After release the first grant is index 4, because the pointer is back at 0.
